// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
//   Sequences the fetch/decode/execute pipeline. It holds the fetch stall and
//   owns the register-file write port while the pipeline is not running. It
//   preloads registers 1..N_REGISTERS-1 from a data stream, runs the pipeline
//   free or for a fixed number of cycles, and drains in-flight instructions
//   before returning to idle.
//
// Ports
//   i_clk / i_reset          clock (rising edge), async active-low reset
//   i_cmd_valid/i_cmd        command strobe and code (1 LOAD_REGS, 2 RUN,
//                            3 STEP, 4 HALT, anything else is a NOP)
//   i_step_count             cycle count, sampled with STEP
//   o_cmd_ready              command accepted when valid && ready
//   i_load_valid/i_load_data register preload stream
//   o_load_ready             preload handshake ready
//   i_halt_detect            pipeline saw a halt instruction
//   i_pipe_wb_reg_*          register write from the pipeline
//   o_wb_reg_*               muxed register-file write port
//   o_if_stall               fetch stall
//   o_state                  current state code
//   o_cycle_count            saturating count of unstalled cycles
//   o_done                   one-cycle pulse when an operation completes
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | pipeline stalled, waiting for a command
// LOAD  | streaming preload data into registers 1..N_REGISTERS-1
// RUN   | pipeline free-running until HALT or a halt instruction
// STEP  | pipeline running for the latched number of cycles
// DRAIN | stall held for N_DRAIN cycles so in-flight work retires

module pipeline_run_controller #(
  parameter int NB_DATA           = 32,
  parameter int N_REGISTERS       = 32,
  parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS),
  parameter int NB_STEP_CNT       = 16,
  parameter int N_DRAIN           = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_cmd_valid,
  input  logic [2:0]                   i_cmd,
  input  logic [NB_STEP_CNT-1:0]       i_step_count,
  output logic                         o_cmd_ready,
  input  logic                         i_load_valid,
  input  logic [NB_DATA-1:0]           i_load_data,
  output logic                         o_load_ready,
  input  logic                         i_halt_detect,
  input  logic [NB_DATA-1:0]           i_pipe_wb_reg_data,
  input  logic [NB_ADDR_REGISTERS-1:0] i_pipe_wb_reg_addr,
  input  logic                         i_pipe_wb_reg_en,
  output logic [NB_DATA-1:0]           o_wb_reg_data,
  output logic [NB_ADDR_REGISTERS-1:0] o_wb_reg_addr,
  output logic                         o_wb_reg_en,
  output logic                         o_if_stall,
  output logic [2:0]                   o_state,
  output logic [31:0]                  o_cycle_count,
  output logic                         o_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] CMD_LOAD = 3'd1;
  localparam logic [2:0] CMD_RUN  = 3'd2;
  localparam logic [2:0] CMD_STEP = 3'd3;
  localparam logic [2:0] CMD_HALT = 3'd4;

  localparam int NB_DRAIN = $clog2(N_DRAIN + 1);
  localparam logic [NB_ADDR_REGISTERS-1:0] LAST_REG = NB_ADDR_REGISTERS'(N_REGISTERS - 1);
  localparam logic [NB_ADDR_REGISTERS-1:0] FIRST_REG = NB_ADDR_REGISTERS'(1);

  state_t                         state_q, state_d;
  logic [NB_STEP_CNT-1:0]         step_cnt_q, step_cnt_d;
  logic [NB_DRAIN-1:0]            drain_cnt_q, drain_cnt_d;
  logic [NB_ADDR_REGISTERS-1:0]   ptr_q, ptr_d;
  logic [31:0]                    cycle_cnt_q, cycle_cnt_d;
  logic                           if_stall_q, if_stall_d;
  logic                           done_q, done_d;
  logic                           ctl_wb_en_q, ctl_wb_en_d;
  logic [NB_ADDR_REGISTERS-1:0]   ctl_wb_addr_q, ctl_wb_addr_d;
  logic [NB_DATA-1:0]             ctl_wb_data_q, ctl_wb_data_d;

  logic cmd_fire;
  logic halt_cmd;
  logic ctl_owns_port;

  assign o_cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_load_ready = (state_q == ST_LOAD);
  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign halt_cmd     = cmd_fire && (i_cmd == CMD_HALT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= ST_IDLE;
      step_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      ptr_q         <= FIRST_REG;
      cycle_cnt_q   <= '0;
      if_stall_q    <= 1'b1;
      done_q        <= 1'b0;
      ctl_wb_en_q   <= 1'b0;
      ctl_wb_addr_q <= '0;
      ctl_wb_data_q <= '0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      ptr_q         <= ptr_d;
      cycle_cnt_q   <= cycle_cnt_d;
      if_stall_q    <= if_stall_d;
      done_q        <= done_d;
      ctl_wb_en_q   <= ctl_wb_en_d;
      ctl_wb_addr_q <= ctl_wb_addr_d;
      ctl_wb_data_q <= ctl_wb_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_cnt_d    = step_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    ptr_d         = ptr_q;
    cycle_cnt_d   = cycle_cnt_q;
    done_d        = 1'b0;
    ctl_wb_en_d   = 1'b0;
    ctl_wb_addr_d = ctl_wb_addr_q;
    ctl_wb_data_d = ctl_wb_data_q;

    if (!if_stall_q && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_LOAD: begin
              state_d     = ST_LOAD;
              cycle_cnt_d = '0;
              ptr_d       = FIRST_REG;
            end
            CMD_RUN: state_d = ST_RUN;
            CMD_STEP: begin
              if (i_step_count != '0) begin
                state_d    = ST_STEP;
                step_cnt_d = i_step_count;
              end else begin
                done_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (i_load_valid) begin
          ctl_wb_en_d   = 1'b1;
          ctl_wb_addr_d = ptr_q;
          ctl_wb_data_d = i_load_data;
          ptr_d         = ptr_q + FIRST_REG;
          if (ptr_q == LAST_REG) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ptr_d   = FIRST_REG;
          end
        end
      end
      ST_RUN: begin
        if (halt_cmd || i_halt_detect) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = NB_DRAIN'(N_DRAIN);
        end
      end
      ST_STEP: begin
        // The step counter is checked for its terminal value first, so a HALT
        // landing in the final step cycle still yields the full N cycles.
        if (halt_cmd || (step_cnt_q == NB_STEP_CNT'(1))) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = NB_DRAIN'(N_DRAIN);
        end else begin
          step_cnt_d = step_cnt_q - NB_STEP_CNT'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == NB_DRAIN'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if_stall_d = !((state_d == ST_RUN) || (state_d == ST_STEP));
  end

  // The final preload write is presented in the first IDLE cycle, so the
  // controller keeps the port for as long as one of its writes is pending.
  assign ctl_owns_port = (state_q == ST_LOAD) || ctl_wb_en_q;

  assign o_wb_reg_en   = ctl_owns_port ? ctl_wb_en_q   : i_pipe_wb_reg_en;
  assign o_wb_reg_addr = ctl_owns_port ? ctl_wb_addr_q : i_pipe_wb_reg_addr;
  assign o_wb_reg_data = ctl_owns_port ? ctl_wb_data_q : i_pipe_wb_reg_data;

  assign o_if_stall    = if_stall_q;
  assign o_state       = state_q;
  assign o_cycle_count = cycle_cnt_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
module tb_pipeline_run_controller;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [2:0]  i_cmd = 3'd0;
  logic [15:0] i_step_count = 16'd0;
  logic        o_cmd_ready;
  logic        i_load_valid = 1'b0;
  logic [31:0] i_load_data = 32'd0;
  logic        o_load_ready;
  logic        i_halt_detect = 1'b0;
  logic [31:0] i_pipe_wb_reg_data = 32'd0;
  logic [4:0]  i_pipe_wb_reg_addr = 5'd0;
  logic        i_pipe_wb_reg_en = 1'b0;
  logic [31:0] o_wb_reg_data;
  logic [4:0]  o_wb_reg_addr;
  logic        o_wb_reg_en;
  logic        o_if_stall;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;
  logic        o_done;

  always #5 i_clk = ~i_clk;

  pipeline_run_controller dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_cmd_valid        (i_cmd_valid),
    .i_cmd              (i_cmd),
    .i_step_count       (i_step_count),
    .o_cmd_ready        (o_cmd_ready),
    .i_load_valid       (i_load_valid),
    .i_load_data        (i_load_data),
    .o_load_ready       (o_load_ready),
    .i_halt_detect      (i_halt_detect),
    .i_pipe_wb_reg_data (i_pipe_wb_reg_data),
    .i_pipe_wb_reg_addr (i_pipe_wb_reg_addr),
    .i_pipe_wb_reg_en   (i_pipe_wb_reg_en),
    .o_wb_reg_data      (o_wb_reg_data),
    .o_wb_reg_addr      (o_wb_reg_addr),
    .o_wb_reg_en        (o_wb_reg_en),
    .o_if_stall         (o_if_stall),
    .o_state            (o_state),
    .o_cycle_count      (o_cycle_count),
    .o_done             (o_done)
  );

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic        v;
    logic [2:0]  cmd;
    logic [15:0] cnt;
    logic        hd;
    logic [2:0]  st;
    logic        stall;
    logic        done;
    logic        rdy;
  } vec_t;
  vec_t vecs[$];

  localparam logic [2:0] C_LOAD = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3, C_HALT = 3'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_wb();
    wr_t w;
    if (o_wb_reg_en === 1'b1) begin
      writes_seen++;
      if (sb_q.size() == 0) begin
        chk("wb_unexpected_en", 32'(o_wb_reg_en), 32'd0);
      end else begin
        w = sb_q.pop_front();
        chk("wb_addr", 32'(o_wb_reg_addr), 32'(w.addr));
        chk("wb_data", o_wb_reg_data, w.data);
      end
    end
  endtask

  task automatic load_beat(input logic valid, input logic pipe_wr,
                           input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    i_load_valid       = valid;
    i_load_data        = data;
    i_pipe_wb_reg_en   = pipe_wr;
    i_pipe_wb_reg_addr = 5'd7;
    i_pipe_wb_reg_data = 32'hDEAD_BEEF;
    if (valid && o_load_ready) begin
      w.addr = addr;
      w.data = data;
      sb_q.push_back(w);
    end
    step_clk();
    i_load_valid = 1'b0;
    check_wb();
    i_pipe_wb_reg_en = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [15:0] cnt);
    i_cmd_valid  = 1'b1;
    i_cmd        = cmd;
    i_step_count = cnt;
    step_clk();
    i_cmd_valid  = 1'b0;
    i_cmd        = 3'd0;
  endtask

  // Observes from the current cycle until o_done is seen or the budget runs out.
  task automatic wait_done(input int budget, output int unst, output int drains, output logic got);
    unst = 0; drains = 0; got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      if (o_if_stall == 1'b0) unst++;
      if (o_state == 3'd4) drains++;
      step_clk();
      if (o_done) got = 1'b1;
    end
  endtask

  task automatic add_vec(input logic v, input logic [2:0] cmd, input logic [15:0] cnt,
                         input logic hd, input logic [2:0] st, input logic stall,
                         input logic done, input logic rdy);
    vec_t x;
    x.v = v; x.cmd = cmd; x.cnt = cnt; x.hd = hd;
    x.st = st; x.stall = stall; x.done = done; x.rdy = rdy;
    vecs.push_back(x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    int unst, drains, i, iter;
    logic got, prev_stall;

    // reset
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_stall", 32'(o_if_stall), 32'd1);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_wb_en", 32'(o_wb_reg_en), 32'd0);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_count", o_cycle_count, 32'd0);
    i_reset = 1'b1;
    step_clk();

    // table: v cmd cnt hd | state stall done ready
    add_vec(1, 3'd6,   0,  0, 0, 1, 0, 1);
    add_vec(1, C_HALT, 0,  0, 0, 1, 0, 1);
    add_vec(1, C_STEP, 0,  0, 0, 1, 1, 1);
    add_vec(0, 0,      0,  0, 0, 1, 0, 1);
    add_vec(1, C_STEP, 2,  0, 3, 0, 0, 1);
    add_vec(0, 0,      0,  0, 3, 0, 0, 1);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 0, 1, 1, 1);
    add_vec(0, 0,      0,  0, 0, 1, 0, 1);
    add_vec(1, C_RUN,  0,  0, 2, 0, 0, 1);
    add_vec(0, 0,      0,  0, 2, 0, 0, 1);
    add_vec(1, C_HALT, 0,  1, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 0, 1, 1, 1);
    add_vec(0, 0,      0,  1, 0, 1, 0, 1);
    add_vec(1, C_STEP, 3,  0, 3, 0, 0, 1);
    add_vec(0, 0,      0,  0, 3, 0, 0, 1);
    add_vec(0, 0,      0,  0, 3, 0, 0, 1);
    add_vec(1, C_HALT, 0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 0, 1, 1, 1);
    add_vec(1, C_STEP, 10, 0, 3, 0, 0, 1);
    add_vec(1, C_RUN,  0,  0, 3, 0, 0, 1);
    add_vec(1, C_HALT, 0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 4, 1, 0, 0);
    add_vec(0, 0,      0,  0, 0, 1, 1, 1);
    add_vec(0, 0,      0,  0, 0, 1, 0, 1);

    exp_cnt = 0;
    prev_stall = 1'b1;
    foreach (vecs[k]) begin
      i_cmd_valid   = vecs[k].v;
      i_cmd         = vecs[k].cmd;
      i_step_count  = vecs[k].cnt;
      i_halt_detect = vecs[k].hd;
      if (!prev_stall) exp_cnt++;
      step_clk();
      i_cmd_valid   = 1'b0;
      i_cmd         = 3'd0;
      i_halt_detect = 1'b0;
      chk($sformatf("vec%0d_state", k), 32'(o_state), 32'(vecs[k].st));
      chk($sformatf("vec%0d_stall", k), 32'(o_if_stall), 32'(vecs[k].stall));
      chk($sformatf("vec%0d_done", k), 32'(o_done), 32'(vecs[k].done));
      chk($sformatf("vec%0d_ready", k), 32'(o_cmd_ready), 32'(vecs[k].rdy));
      chk($sformatf("vec%0d_count", k), o_cycle_count, 32'(exp_cnt));
      prev_stall = vecs[k].stall;
    end

    // register preload with gaps and pipe writes that must be dropped
    send_cmd(C_LOAD, 0);
    exp_cnt = 0;
    chk("load_state", 32'(o_state), 32'd1);
    chk("load_ready", 32'(o_load_ready), 32'd1);
    chk("load_cmd_ready", 32'(o_cmd_ready), 32'd0);
    chk("load_count_clr", o_cycle_count, 32'd0);
    writes_seen = 0;
    i = 1; iter = 0;
    while (i <= 31 && iter < 200) begin
      iter++;
      if (iter % 4 == 3) begin
        load_beat(1'b0, 1'b1, 5'd0, 32'd0);
      end else begin
        load_beat(1'b1, 1'b0, 5'(i), 32'(i + 64));
        i++;
      end
    end
    chk("load_writes", 32'(writes_seen), 32'd31);
    chk("load_done", 32'(o_done), 32'd1);
    chk("load_end_state", 32'(o_state), 32'd0);
    chk("load_sb_empty", 32'(sb_q.size()), 32'd0);
    step_clk();
    chk("load_done_pulse", 32'(o_done), 32'd0);
    chk("load_wb_en_after", 32'(o_wb_reg_en), 32'd0);

    // STEP 5
    send_cmd(C_STEP, 16'd5);
    wait_done(40, unst, drains, got);
    exp_cnt += 5;
    chk("step5_done", 32'(got), 32'd1);
    chk("step5_unstalled", 32'(unst), 32'd5);
    chk("step5_drain", 32'(drains), 32'd4);
    chk("step5_count", o_cycle_count, 32'(exp_cnt));

    // RUN, halt_detect in the 40th cycle; then RUN with a HALT command
    for (int pass = 0; pass < 2; pass++) begin
      send_cmd(C_RUN, 0);
      unst = 0;
      for (int c = 0; c < 40; c++) begin
        if (o_if_stall == 1'b0) unst++;
        if (c == 39) begin
          if (pass == 0) i_halt_detect = 1'b1;
          else begin i_cmd_valid = 1'b1; i_cmd = C_HALT; end
        end
        step_clk();
        i_halt_detect = 1'b0;
        i_cmd_valid   = 1'b0;
        i_cmd         = 3'd0;
      end
      exp_cnt += 40;
      chk($sformatf("run%0d_unstalled", pass), 32'(unst), 32'd40);
      chk($sformatf("run%0d_drain_state", pass), 32'(o_state), 32'd4);
      wait_done(20, unst, drains, got);
      chk($sformatf("run%0d_done", pass), 32'(got), 32'd1);
      chk($sformatf("run%0d_drain_cycles", pass), 32'(drains), 32'd4);
      chk($sformatf("run%0d_count", pass), o_cycle_count, 32'(exp_cnt));
    end

    // abort: reset while the load pointer sits at 10
    send_cmd(C_LOAD, 0);
    for (int k = 1; k <= 9; k++) load_beat(1'b1, 1'b0, 5'(k), 32'(k + 32'h100));
    #2;
    i_reset = 1'b0;
    #1;
    chk("abort_state", 32'(o_state), 32'd0);
    chk("abort_stall", 32'(o_if_stall), 32'd1);
    chk("abort_wb_en", 32'(o_wb_reg_en), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    step_clk();
    i_reset = 1'b1;
    step_clk();
    chk("abort_no_done", 32'(o_done), 32'd0);
    chk("abort_count", o_cycle_count, 32'd0);
    send_cmd(C_LOAD, 0);
    writes_seen = 0;
    load_beat(1'b1, 1'b0, 5'd1, 32'hA5A5_0001);
    chk("reload_write_seen", 32'(writes_seen), 32'd1);
    chk("reload_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
